// File: rtl/alu_pkg.sv
// Shared types and helpers for the alu_mc multicycle execute unit.
// ALU_DIV_EN selects whether DIV runs on the iterative divider.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_XOR  = 4'h2,
    OP_ANDN = 4'h3,
    OP_ROL  = 4'h4,
    OP_SLL  = 4'h5,
    OP_ROR  = 4'h6,
    OP_SRL  = 4'h7,
    OP_SEQ  = 4'h8,
    OP_SLT  = 4'h9,
    OP_SLE  = 4'hA,
    OP_SCO  = 4'hB,
    OP_MUL  = 4'hC,
    OP_DIV  = 4'hD
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } alu_state_t;

  function automatic logic is_multicycle(
    input logic [3:0] op
  );
`ifdef ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response handshake bundle between decode, alu_mc and writeback.
// master drives operations and out_ready; slave is the execute unit.
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] rem;
  logic             err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, rem, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, rem, err
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle.
// Divider datapath exists only when ALU_DIV_EN is defined.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef ALU_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
`ifdef ALU_DIV_EN
  output logic [WIDTH-1:0] rem,
`endif
  output logic [WIDTH-1:0] res
);
  localparam int LW = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_sr;
  logic [WIDTH-1:0] step_opnd;
`ifdef ALU_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] div_acc;
  logic [WIDTH-1:0] div_sr;
`endif

  assign done = busy_q & (cnt_q == '0);

  always_comb begin
    mul_acc   = acc_q + (sr_q[0] ? opnd_q : '0);
    step_acc  = mul_acc;
    step_sr   = sr_q >> 1;
    step_opnd = opnd_q << 1;
    res       = mul_acc;
`ifdef ALU_DIV_EN
    // acc holds the partial remainder, sr shifts dividend out / quotient in
    shifted = {acc_q, sr_q[WIDTH-1]};
    ge      = shifted >= {1'b0, opnd_q};
    div_acc = ge ? WIDTH'(shifted - {1'b0, opnd_q})
                 : shifted[WIDTH-1:0];
    div_sr  = {sr_q[WIDTH-2:0], ge};
    rem     = div_acc;
    if (div_q) begin
      step_acc  = div_acc;
      step_sr   = div_sr;
      step_opnd = opnd_q;
      res       = div_sr;
    end
`endif
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    sr_d   = sr_q;
    opnd_d = opnd_q;
`ifdef ALU_DIV_EN
    div_d  = div_q;
`endif
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = LW'(WIDTH - 1);
      acc_d  = '0;
      sr_d   = b;
      opnd_d = a;
`ifdef ALU_DIV_EN
      div_d  = is_div;
      if (is_div) begin
        sr_d   = a;
        opnd_d = b;
      end
`endif
    end else if (busy_q) begin
      acc_d  = step_acc;
      sr_d   = step_sr;
      opnd_d = step_opnd;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      sr_q   <= '0;
      opnd_q <= '0;
`ifdef ALU_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      sr_q   <= sr_d;
      opnd_q <= opnd_d;
`ifdef ALU_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multicycle execute unit: single-cycle ALU ops plus iterative MUL/DIV.
// Define ALU_DIV_EN to build the divider; otherwise DIV flags err.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mc_if.slave  io
);
  localparam int LW = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             err_q, err_d;

  logic             accept;
  logic             seq_start;
  logic             seq_done;
  logic [WIDTH-1:0] seq_res;
  logic [WIDTH-1:0] seq_rem;

  logic [WIDTH:0]   sum;
  logic [LW-1:0]    sh;
  logic [WIDTH-1:0] rol;
  logic [WIDTH-1:0] ror;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] sc_rem;
  logic             sc_err;

  assign io.in_ready  = (state_q == S_IDLE)
                      | ((state_q == S_DONE) & io.out_ready);
  assign io.out_valid = (state_q == S_DONE);
  assign io.result    = result_q;
  assign io.rem       = rem_q;
  assign io.err       = err_q;

  assign accept    = io.in_valid & io.in_ready;
  // divide-by-zero never enters the iterative path
  assign seq_start = accept & is_multicycle(io.op)
                   & ~((io.op == OP_DIV) && (io.b == '0));

  alu_muldiv_seq #(
    .WIDTH (WIDTH)
  ) u_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (seq_start),
`ifdef ALU_DIV_EN
    .is_div (io.op == OP_DIV),
    .rem    (seq_rem),
`endif
    .a      (io.a),
    .b      (io.b),
    .done   (seq_done),
    .res    (seq_res)
  );

`ifndef ALU_DIV_EN
  assign seq_rem = '0;
`endif

  always_comb begin
    sum = {1'b0, io.a} + {1'b0, io.b};
    sh  = io.b[LW-1:0];
    rol = '0;
    ror = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rol[i] = io.a[LW'(i) - sh];
      ror[i] = io.a[LW'(i) + sh];
    end
    sc_res = '0;
    sc_rem = '0;
    sc_err = 1'b0;
    case (io.op)
      OP_ADD:  sc_res = sum[WIDTH-1:0];
      OP_SUB:  sc_res = io.b - io.a;
      OP_XOR:  sc_res = io.a ^ io.b;
      OP_ANDN: sc_res = io.a & ~io.b;
      OP_ROL:  sc_res = rol;
      OP_SLL:  sc_res = io.a << sh;
      OP_ROR:  sc_res = ror;
      OP_SRL:  sc_res = io.a >> sh;
      OP_SEQ:  sc_res = WIDTH'(io.a == io.b);
      OP_SLT:  sc_res = WIDTH'($signed(io.a) < $signed(io.b));
      OP_SLE:  sc_res = WIDTH'($signed(io.a) <= $signed(io.b));
      OP_SCO:  sc_res = WIDTH'(sum[WIDTH]);
      OP_DIV: begin
`ifdef ALU_DIV_EN
        sc_res = '1;
        sc_rem = io.a;
`endif
        sc_err = 1'b1;
      end
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = seq_start ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        if (seq_done) state_d = S_DONE;
      end
      S_DONE: begin
        if (io.out_ready) begin
          if (accept) state_d = seq_start ? S_BUSY : S_DONE;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    result_d = result_q;
    rem_d    = rem_q;
    err_d    = err_q;
    if (seq_done) begin
      result_d = seq_res;
      rem_d    = seq_rem;
      err_d    = 1'b0;
    end else if (seq_start) begin
      result_d = '0;
      rem_d    = '0;
      err_d    = 1'b0;
    end else if (accept) begin
      result_d = sc_res;
      rem_d    = sc_rem;
      err_d    = sc_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed + randomized bench for alu_mc (WIDTH=16) against an
// arithmetic reference model.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  alu_mc_if #(.WIDTH(W)) io ();

  alu_mc #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input int op,
                                input longint unsigned a,
                                input longint unsigned b,
                                output longint unsigned res,
                                output longint unsigned rm,
                                output logic er,
                                output int lat);
    longint unsigned m;
    longint sa, sb;
    int s;
    m   = 64'hFFFF;
    s   = int'(b % 16);
    sa  = (a >= 32768) ? longint'(a) - 65536 : longint'(a);
    sb  = (b >= 32768) ? longint'(b) - 65536 : longint'(b);
    res = 0;
    rm  = 0;
    er  = 1'b0;
    lat = 1;
    case (op)
      0:  res = (a + b) & m;
      1:  res = (b - a) & m;
      2:  res = a ^ b;
      3:  res = a & ~b & m;
      4:  res = ((a << s) | (a >> (16 - s))) & m;
      5:  res = (a << s) & m;
      6:  res = ((a >> s) | (a << (16 - s))) & m;
      7:  res = a >> s;
      8:  res = (a == b) ? 1 : 0;
      9:  res = (sa < sb) ? 1 : 0;
      10: res = (sa <= sb) ? 1 : 0;
      11: res = (a + b) >> 16;
      12: begin
        res = (a * b) & m;
        lat = W + 1;
      end
      13: begin
        er = 1'b1;
`ifdef ALU_DIV_EN
        if (b == 0) begin
          res = m;
          rm  = a;
        end else begin
          res = a / b;
          rm  = a % b;
          er  = 1'b0;
          lat = W + 1;
        end
`endif
      end
      default: res = 0;
    endcase
  endfunction

  task automatic run_op(input int op,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input string tag);
    longint unsigned eres, erem;
    logic eerr, rdy_bad;
    int elat, lat, n;
    model(op, a, b, eres, erem, eerr, elat);
    io.op       = op[3:0];
    io.a        = a;
    io.b        = b;
    io.in_valid = 1'b1;
    n = 0;
    #1;
    while (!io.in_ready && n < 50) begin
      step();
      n++;
    end
    chk($sformatf("%s_in_ready", tag), 64'(io.in_ready), 64'd1);
    step();
    io.in_valid = 1'b0;
    io.a        = ~a;
    io.b        = ~b;
    lat = 1;
    rdy_bad = 1'b0;
    while (!io.out_valid && lat < 40) begin
      if (io.in_ready) rdy_bad = 1'b1;
      step();
      lat++;
    end
    chk($sformatf("%s_latency", tag), 64'(lat), 64'(elat));
    chk($sformatf("%s_result", tag), 64'(io.result), eres);
    chk($sformatf("%s_rem", tag), 64'(io.rem), erem);
    chk($sformatf("%s_err", tag), 64'(io.err), 64'(eerr));
    if (elat > 1) chk($sformatf("%s_busy_ready", tag),
                      64'(rdy_bad), 64'd0);
  endtask

  initial begin
    logic bad;
    int op;
    logic [15:0] ra, rb;
    longint unsigned eres, erem;
    logic eerr;
    int elat;

    io.in_valid  = 1'b0;
    io.op        = 4'h0;
    io.a         = '0;
    io.b         = '0;
    io.out_ready = 1'b1;

    rst_n = 1'b0;
    step();
    step();
    chk("rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("rst_result", 64'(io.result), 64'd0);
    chk("rst_rem", 64'(io.rem), 64'd0);
    chk("rst_err", 64'(io.err), 64'd0);
    chk("rst_in_ready", 64'(io.in_ready), 64'd1);
    rst_n = 1'b1;
    step();

    run_op(0, 16'h7FFF, 16'h0001, "add");
    run_op(11, 16'hFFFF, 16'h0001, "sco");
    run_op(12, 16'h0123, 16'h0045, "mul");
    run_op(13, 16'd1000, 16'd7, "div");
    run_op(13, 16'h1234, 16'h0000, "div0");
    run_op(15, 16'h1234, 16'h5678, "unknown");

    // backpressure
    step();
    io.out_ready = 1'b0;
    run_op(6, 16'h0001, 16'h0001, "ror");
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (io.result !== 16'h8000 || io.out_valid !== 1'b1 ||
          io.in_ready !== 1'b0 || io.err !== 1'b0) bad = 1'b1;
    end
    chk("hold_stable", 64'(bad), 64'd0);
    io.op        = 4'h1;
    io.a         = 16'd3;
    io.b         = 16'd10;
    io.in_valid  = 1'b1;
    io.out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 64'(io.in_ready), 64'd1);
    step();
    io.in_valid = 1'b0;
    chk("b2b_valid", 64'(io.out_valid), 64'd1);
    chk("b2b_result", 64'(io.result), 64'h0007);

    // reset during MUL
    io.op       = 4'hC;
    io.a        = 16'h0123;
    io.b        = 16'h0045;
    io.in_valid = 1'b1;
    step();
    io.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_valid", 64'(io.out_valid), 64'd0);
    chk("midrst_result", 64'(io.result), 64'd0);
    chk("midrst_in_ready", 64'(io.in_ready), 64'd1);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (io.out_valid !== 1'b0) bad = 1'b1;
    end
    chk("midrst_no_output", 64'(bad), 64'd0);
    run_op(9, 16'hFFFF, 16'h0000, "slt");

    // random multicycle
    for (int i = 0; i < 6; i++) begin
      op = (i % 2 == 0) ? 12 : 13;
      ra = 16'($urandom);
      rb = (i == 5) ? 16'h0000 : 16'($urandom_range(1, 65535));
      run_op(op, ra, rb, $sformatf("rnd%0d", i));
    end

    // streaming single-cycle ops
    step();
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      op = (i == 10) ? 14 : int'($urandom_range(0, 11));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 3) rb = ra;
      model(op, ra, rb, eres, erem, eerr, elat);
      io.op       = op[3:0];
      io.a        = ra;
      io.b        = rb;
      io.in_valid = 1'b1;
      #1;
      if (io.in_ready !== 1'b1) bad = 1'b1;
      step();
      chk($sformatf("stream%0d_valid", i), 64'(io.out_valid), 64'd1);
      chk($sformatf("stream%0d_result", i), 64'(io.result), eres);
      chk($sformatf("stream%0d_err", i), 64'(io.err), 64'(eerr));
    end
    io.in_valid = 1'b0;
    chk("stream_in_ready", 64'(bad), 64'd0);
    step();
    chk("stream_idle", 64'(io.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
